// File: rtl/ex_flag_unit.sv
// N/Z/V flag register, branch condition evaluation and flag hazard detection.
// Build option: define FLAG_BYPASS_EN to forward same-cycle flag writes to the branch.
module ex_flag_unit #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          ex_stall,
    input  logic          ex_flush,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_ovfl,
    input  logic          br_valid,
    input  logic [2:0]    br_ccc,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_v,
    output logic          br_taken,
    output logic          flag_hazard
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic we;
    logic upd_nv;
    logic upd_z;
    logic nxt_n;
    logic nxt_z;
    logic nxt_v;
    logic eff_n;
    logic eff_z;
    logic eff_v;
    logic cond;

    // ADD/SUB write all three flags; logic/shift ops write Z only.
    always_comb begin
        we     = ex_valid & ~ex_stall & ~ex_flush;
        upd_nv = we & ((ex_opcode == OP_ADD) | (ex_opcode == OP_SUB));
        upd_z  = upd_nv | (we & ((ex_opcode == OP_XOR) | (ex_opcode == OP_SLL) |
                                 (ex_opcode == OP_SRA) | (ex_opcode == OP_ROR)));
        nxt_n  = alu_out[DW-1];
        nxt_z  = (alu_out == '0);
        nxt_v  = alu_ovfl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (upd_nv) begin
                flag_n <= nxt_n;
                flag_v <= nxt_v;
            end
            if (upd_z) begin
                flag_z <= nxt_z;
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    // Forwarding is per flag: only the flags this opcode writes are bypassed.
    always_comb begin
        eff_n = upd_nv ? nxt_n : flag_n;
        eff_z = upd_z  ? nxt_z : flag_z;
        eff_v = upd_nv ? nxt_v : flag_v;
    end

    assign flag_hazard = 1'b0;
`else
    logic pending;

    always_comb begin
        eff_n = flag_n;
        eff_z = flag_z;
        eff_v = flag_v;
    end

    // Covers the cycle right after a flag writer, before the branch may read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else begin
            pending <= upd_z;
        end
    end

    assign flag_hazard = rst_n & br_valid & (upd_z | pending);
`endif

    always_comb begin
        cond = 1'b0;
        case (br_ccc)
            3'b000:  cond = ~eff_z;
            3'b001:  cond = eff_z;
            3'b010:  cond = ~eff_z & ~eff_n;
            3'b011:  cond = eff_n;
            3'b100:  cond = eff_z | ~eff_n;
            3'b101:  cond = eff_n | eff_z;
            3'b110:  cond = eff_v;
            default: cond = 1'b1;
        endcase
        br_taken = br_valid & cond;
    end

endmodule

// File: tb/tb_ex_flag_unit.sv
// Directed self-checking bench for ex_flag_unit; expectations follow the active build option.
module tb_ex_flag_unit;

    localparam int unsigned DW = 16;
`ifdef FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_stall;
    logic          ex_flush;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] alu_out;
    logic          alu_ovfl;
    logic          br_valid;
    logic [2:0]    br_ccc;
    logic          flag_n;
    logic          flag_z;
    logic          flag_v;
    logic          br_taken;
    logic          flag_hazard;

    int vectors;
    int miscompares;

    ex_flag_unit #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_flush(ex_flush), .ex_opcode(ex_opcode), .alu_out(alu_out),
        .alu_ovfl(alu_ovfl), .br_valid(br_valid), .br_ccc(br_ccc),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .br_taken(br_taken), .flag_hazard(flag_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic n, input logic z, input logic v);
        chk({tag, ".n"}, flag_n, n);
        chk({tag, ".z"}, flag_z, z);
        chk({tag, ".v"}, flag_v, v);
    endtask

    task automatic ex(input logic vld, input logic stl, input logic fl,
                      input logic [3:0] op, input logic [DW-1:0] res, input logic ov);
        ex_valid  = vld;
        ex_stall  = stl;
        ex_flush  = fl;
        ex_opcode = op;
        alu_out   = res;
        alu_ovfl  = ov;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        br_valid    = 1'b0;
        br_ccc      = 3'b000;
        ex(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);

        // Reset held two cycles with a live ADD producing zero.
        step();
        br_valid = 1'b1;
        step();
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.hazard", flag_hazard, 1'b0);
        br_valid = 1'b0;

        rst_n = 1'b1;
        step();
        chk_flags("first_write", 1'b0, 1'b1, 1'b0);

        // Saturated positive overflow.
        ex(1'b1, 1'b0, 1'b0, 4'b0000, 16'h7FFF, 1'b1);
        step();
        chk_flags("add_sat", 1'b0, 1'b0, 1'b1);
        ex(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
        br_valid = 1'b1;
        br_ccc   = 3'b110;
        #1;
        chk("ovfl_taken", br_taken, 1'b1);
        br_ccc = 3'b011;
        #1;
        chk("lt_taken", br_taken, 1'b0);
        br_valid = 1'b0;
        step();

        // SUB to zero then XOR: XOR touches Z only.
        ex(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 1'b0);
        step();
        chk_flags("sub_zero", 1'b0, 1'b1, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 4'b0010, 16'h8000, 1'b1);
        step();
        chk_flags("xor", 1'b0, 1'b0, 1'b0);
        ex(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
        br_valid = 1'b1;
        br_ccc   = 3'b001;
        #1;
        chk("eq_taken", br_taken, 1'b0);
        br_ccc = 3'b000;
        #1;
        chk("ne_taken", br_taken, 1'b1);
        br_valid = 1'b0;
        step();

        // Build N=1 Z=0 V=0, then non-writing cases must hold it.
        ex(1'b1, 1'b0, 1'b0, 4'b0001, 16'h8000, 1'b0);
        step();
        chk_flags("sub_neg", 1'b1, 1'b0, 1'b0);
        ex(1'b1, 1'b0, 1'b1, 4'b0001, 16'h0000, 1'b1);
        step();
        chk_flags("flush", 1'b1, 1'b0, 1'b0);
        ex(1'b1, 1'b1, 1'b0, 4'b0001, 16'h0000, 1'b1);
        step();
        chk_flags("stall", 1'b1, 1'b0, 1'b0);
        ex(1'b1, 1'b1, 1'b1, 4'b0000, 16'h0000, 1'b1);
        step();
        chk_flags("flush_stall", 1'b1, 1'b0, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 4'b0011, 16'h0000, 1'b1);
        step();
        chk_flags("red", 1'b1, 1'b0, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 4'b1000, 16'h0000, 1'b1);
        step();
        chk_flags("op1xxx", 1'b1, 1'b0, 1'b0);
        ex(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
        step();

        // Remaining condition codes on N=1 Z=0 V=0, no writer in flight.
        br_valid = 1'b1;
        br_ccc   = 3'b010;
        #1;
        chk("gt_taken", br_taken, 1'b0);
        chk("no_writer.hazard", flag_hazard, 1'b0);
        br_ccc = 3'b100;
        #1;
        chk("gte_taken", br_taken, 1'b0);
        br_ccc = 3'b101;
        #1;
        chk("lte_taken", br_taken, 1'b1);
        br_ccc = 3'b111;
        #1;
        chk("uncond_taken", br_taken, 1'b1);
        br_valid = 1'b0;
        #1;
        chk("no_branch", br_taken, 1'b0);

        // Same-cycle producer and EQ branch.
        ex(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 1'b0);
        br_valid = 1'b1;
        br_ccc   = 3'b001;
        #1;
        chk("same_cyc0.taken", br_taken, BYP ? 1'b1 : 1'b0);
        chk("same_cyc0.hazard", flag_hazard, BYP ? 1'b0 : 1'b1);
        step();
        ex(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("same_cyc1.hazard", flag_hazard, BYP ? 1'b0 : 1'b1);
        chk_flags("same_cyc1", 1'b0, 1'b1, 1'b0);
        step();
        chk("same_cyc2.hazard", flag_hazard, 1'b0);
        chk("same_cyc2.taken", br_taken, 1'b1);

        // SLL forwards Z only: LT must still see the registered N=0.
        ex(1'b1, 1'b0, 1'b0, 4'b0100, 16'h8000, 1'b1);
        br_ccc = 3'b011;
        #1;
        chk("sll_lt.taken", br_taken, 1'b0);
        br_ccc = 3'b000;
        #1;
        chk("sll_ne.taken", br_taken, BYP ? 1'b1 : 1'b0);
        chk("sll_ne.hazard", flag_hazard, BYP ? 1'b0 : 1'b1);
        step();
        chk_flags("sll", 1'b0, 1'b0, 1'b0);

        // SRA to zero while in a pending window, then reset dominates.
        ex(1'b1, 1'b0, 1'b0, 4'b0101, 16'h0000, 1'b1);
        step();
        chk_flags("sra", 1'b0, 1'b1, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 4'b0000, 16'hFFFF, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_hazard.pre", flag_hazard, 1'b0);
        step();
        chk_flags("rst_dom", 1'b0, 1'b0, 1'b0);
        chk("rst_hazard.post", flag_hazard, 1'b0);
        rst_n    = 1'b1;
        br_valid = 1'b0;
        step();
        chk_flags("post_rst_write", 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
